// File: rtl/fpu_pkg.sv
// Shared single-precision float definitions: FSM states, constants and field helpers.
// Reusable by both the sequential multiplier and the combinational divider.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } fpu_state_e;

  localparam int          MANT_W   = 24;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_INF  = 8'hFF;

  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] f_mant(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/fpu_mant_mult_seq.sv
// Shift-add mantissa multiplier: one partial product per clock, MANT_W clocks per product.
// o_last marks the clock whose edge folds in the final partial product.
module fpu_mant_mult_seq #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [MANT_W-1:0]     i_mcand,
  input  logic [MANT_W-1:0]     i_mplier,
  output logic                  o_last,
  output logic [2*MANT_W-1:0]   o_product
);

  localparam int CNT_W = $clog2(MANT_W);

  logic [2*MANT_W-1:0] r_mcand;
  logic [2*MANT_W-1:0] r_acc;
  logic [MANT_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_run;

  assign o_last    = r_run && (r_cnt == CNT_W'(MANT_W - 1));
  assign o_product = r_acc;

  // Multiplicand walks left and multiplier walks right, so bit cnt adds mcand << cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{MANT_W{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_last) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_multiplication.sv
// Sequential IEEE-754 single-precision multiplier with valid/ready handshakes.
// Truncating (no rounding) and flush-to-zero, matching the combinational divider.
module fpu_multiplication #(
  parameter int MANT_W   = fpu_pkg::MANT_W,
  parameter int EXP_BIAS = fpu_pkg::EXP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  import fpu_pkg::*;

  fpu_state_e          r_state;
  logic                r_sign;
  logic [7:0]          r_ea;
  logic [7:0]          r_eb;
  logic [31:0]         r_result;
  logic                r_out_valid;

  logic                w_start;
  logic                w_last;
  logic [2*MANT_W-1:0] w_prod;
  logic                w_sign;
  logic                w_special;
  logic [31:0]         w_special_res;
  logic signed [9:0]   w_e_base;
  logic signed [9:0]   w_e;
  logic [22:0]         w_mant;
  logic [31:0]         w_norm_res;
  logic                w_unused_prod;

  assign in_ready      = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign out_valid     = r_out_valid;
  assign result        = r_result;
  assign w_sign        = f_sign(op_a) ^ f_sign(op_b);
  assign w_start       = in_ready && in_valid && !w_special;
  assign w_unused_prod = ^w_prod[22:0];

  // Operand classification: any exponent of 0 or 255 bypasses the mantissa engine.
  always_comb begin
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero        = (f_exp(op_a) == 8'h00);
    b_zero        = (f_exp(op_b) == 8'h00);
    a_inf         = (f_exp(op_a) == EXP_INF) && (f_mant(op_a) == 23'h0);
    b_inf         = (f_exp(op_b) == EXP_INF) && (f_mant(op_b) == 23'h0);
    a_nan         = (f_exp(op_a) == EXP_INF) && (f_mant(op_a) != 23'h0);
    b_nan         = (f_exp(op_b) == EXP_INF) && (f_mant(op_b) != 23'h0);
    w_special     = 1'b1;
    w_special_res = 32'h0000_0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      w_special_res = QNAN;
    end else if (a_inf || b_inf) begin
      w_special_res = {w_sign, EXP_INF, 23'h0};
    end else if (a_zero || b_zero) begin
      w_special_res = {w_sign, 31'h0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Exponent fits 10-bit signed: worst case 254+254-127+1 = 382, least 1+1-127 = -125.
  always_comb begin
    w_e_base = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - $signed(10'(EXP_BIAS));
    if (w_prod[2*MANT_W-1]) begin
      w_mant = w_prod[46:24];
      w_e    = w_e_base + 10'sd1;
    end else begin
      w_mant = w_prod[45:23];
      w_e    = w_e_base;
    end
    if (w_e >= 10'sd255) begin
      w_norm_res = {r_sign, EXP_INF, 23'h0};
    end else if (w_e <= 10'sd0) begin
      w_norm_res = {r_sign, 31'h0};
    end else begin
      w_norm_res = {r_sign, w_e[7:0], w_mant};
    end
  end

  fpu_mant_mult_seq #(
    .MANT_W   (MANT_W)
  ) u_mant_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_mcand  ({1'b1, f_mant(op_a)}),
    .i_mplier ({1'b1, f_mant(op_b)}),
    .o_last   (w_last),
    .o_product(w_prod)
  );

  // Control FSM; result register is only written on DONE entry so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_ea        <= 8'h00;
      r_eb        <= 8'h00;
      r_result    <= 32'h0000_0000;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            r_ea   <= f_exp(op_a);
            r_eb   <= f_exp(op_b);
            if (w_special) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_MULT;
            end
          end
        end
        ST_MULT: begin
          if (w_last) begin
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_result    <= w_norm_res;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_multiplication.sv
// Self-checking bench for fpu_multiplication: directed table, handshake/reset sequences,
// and randomized operands against an arithmetic reference model.
module tb_fpu_multiplication;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_multiplication dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: real-number product of the two significands, truncated to 23 fraction bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, p;
    logic [22:0] m;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 23'h0);
    b_inf  = (eb == 255) && (b[22:0] == 23'h0);
    a_nan  = (ea == 255) && (a[22:0] != 23'h0);
    b_nan  = (eb == 255) && (b[22:0] != 23'h0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h0000_8000_0000_0000) begin
      m = 23'(p / 64'd16777216);
      e = e + 1;
    end else begin
      m = 23'(p / 64'd8388608);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 1;
    return 26;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int kind;
    v    = $urandom;
    kind = $urandom_range(0, 11);
    case (kind)
      0: v[30:0] = 31'h0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'(($urandom_range(0, 1) == 0) ? $urandom_range(1, 10) : $urandom_range(240, 254));
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  // One operation: accept, measure latency, optional backpressure and busy-time in_valid pulses.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        input bit pulse, output logic [31:0] res, output int lat);
    logic [31:0] held;
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    lat      = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      if (pulse && lat >= 5 && lat <= 8) begin
        chk("in_ready_low_while_busy", 32'(in_ready), 32'd0);
        chk("busy_high_while_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        op_a     = 32'h3F80_0000;
        op_b     = 32'h3F80_0000;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    res  = result;
    held = result;
    chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_result_stable", result, held);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          seen;

    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 26};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 26};
    vecs[2]  = '{32'h4303_0000, 32'h3F00_0000, 32'h4283_0000, 26};
    vecs[3]  = '{32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1};
    vecs[4]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1};
    vecs[5]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1};
    vecs[6]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 26};
    vecs[7]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 26};
    vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1};
    vecs[9]  = '{32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1};
    vecs[10] = '{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 26};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, 1'b0, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure for 10 cycles with in_valid pulses during MULT.
    run_op(32'h4000_0000, 32'h4040_0000, 10, 1'b1, res, lat);
    chk("bp_result", res, 32'h40C0_0000);
    chk("bp_latency", 32'(lat), 32'd26);

    // Abort at MULT cycle 10.
    @(negedge clk);
    op_a     = 32'h4000_0000;
    op_b     = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'h0);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    run_op(32'h4000_0000, 32'h4040_0000, 0, 1'b0, res, lat);
    chk("post_abort_result", res, 32'h40C0_0000);
    chk("post_abort_latency", 32'(lat), 32'd26);

    // Randomized back-to-back operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      a = rand_operand();
      b = rand_operand();
      run_op(a, b, $urandom_range(0, 3), 1'b0, res, lat);
      chk($sformatf("rand%0d_result a=%h b=%h", n, a, b), res, ref_mul(a, b));
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_lat(a, b)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
